// File: rtl/bbox_collector.sv
// Per-label bounding-box and area accumulator over a labelled pixel stream.
// At frame end it streams one record per label that was seen, in ascending label order.
module bbox_collector #(
  parameter int unsigned LBL_WIDTH    = 8,
  parameter int unsigned LOC_SIZE     = 11,
  parameter int unsigned FRAME_WIDTH  = 640,
  parameter int unsigned FRAME_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [LBL_WIDTH-1:0]  label,
  input  logic [LOC_SIZE-1:0]   x,
  input  logic [LOC_SIZE-1:0]   y,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LBL_WIDTH-1:0]  out_label,
  output logic [LOC_SIZE-1:0]   out_min_x,
  output logic [LOC_SIZE-1:0]   out_max_x,
  output logic [LOC_SIZE-1:0]   out_min_y,
  output logic [LOC_SIZE-1:0]   out_max_y,
  output logic [2*LOC_SIZE-1:0] out_area,
  output logic                  frame_done,
  output logic                  dropped
);

  localparam int unsigned Depth = 2 ** LBL_WIDTH;
  localparam int unsigned AreaW = 2 * LOC_SIZE;

  typedef logic [LOC_SIZE-1:0] loc_t;

  typedef struct packed {
    logic             valid;
    loc_t             min_x;
    loc_t             max_x;
    loc_t             min_y;
    loc_t             max_y;
    logic [AreaW-1:0] area;
  } entry_t;

  typedef enum logic [2:0] {StClear, StAccum, StDrain, StDump, StDone} state_e;

  state_e               state_q, state_d;
  logic [LBL_WIDTH-1:0] addr_q, addr_d;
  logic                 drain_q, drain_d;
  logic                 dropped_q;

  entry_t mem [Depth];

  logic                 s1_valid_q, s2_valid_q;
  logic [LBL_WIDTH-1:0] s1_label_q, s2_label_q;
  loc_t                 s1_x_q, s1_y_q;
  entry_t               s2_entry_q;

  entry_t               base, merged, dump_entry;
  logic                 take, frame_end;
  logic                 we;
  logic [LBL_WIDTH-1:0] waddr;
  entry_t               wdata;

  assign frame_end  = en && (x == loc_t'(FRAME_WIDTH - 1)) && (y == loc_t'(FRAME_HEIGHT - 1));
  assign take       = (state_q == StAccum) && en && (label != '0);
  assign dump_entry = mem[addr_q];

  // Read stage: a same-label update still sitting in the write stage overrides stale table data.
  always_comb begin
    base = mem[s1_label_q];
    if (s2_valid_q && (s2_label_q == s1_label_q)) begin
      base = s2_entry_q;
    end
    merged = base;
    if (!base.valid) begin
      merged.valid = 1'b1;
      merged.min_x = s1_x_q;
      merged.max_x = s1_x_q;
      merged.min_y = s1_y_q;
      merged.max_y = s1_y_q;
      merged.area  = AreaW'(1);
    end else begin
      if (s1_x_q < base.min_x) merged.min_x = s1_x_q;
      if (s1_x_q > base.max_x) merged.max_x = s1_x_q;
      if (s1_y_q < base.min_y) merged.min_y = s1_y_q;
      if (s1_y_q > base.max_y) merged.max_y = s1_y_q;
      if (!(&base.area)) merged.area = base.area + AreaW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    drain_d    = drain_q;
    out_valid  = 1'b0;
    frame_done = 1'b0;
    // The write stage only holds data in ACCUM/DRAIN, so it never collides with the others.
    we         = s2_valid_q;
    waddr      = s2_label_q;
    wdata      = s2_entry_q;
    case (state_q)
      StClear: begin
        we     = 1'b1;
        waddr  = addr_q;
        wdata  = '0;
        addr_d = addr_q + LBL_WIDTH'(1);
        if (addr_q == '1) state_d = StAccum;
      end
      StAccum: begin
        if (frame_end) begin
          state_d = StDrain;
          drain_d = 1'b0;
        end
      end
      StDrain: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = StDump;
          addr_d  = LBL_WIDTH'(1);
        end
      end
      StDump: begin
        out_valid = dump_entry.valid;
        if (!dump_entry.valid || out_ready) begin
          if (dump_entry.valid) begin
            we    = 1'b1;
            waddr = addr_q;
            wdata = '0;
          end
          addr_d = addr_q + LBL_WIDTH'(1);
          if (addr_q == '1) state_d = StDone;
        end
      end
      StDone: begin
        frame_done = 1'b1;
        state_d    = StAccum;
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StClear;
      addr_q     <= '0;
      drain_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      drain_q    <= drain_d;
      s1_valid_q <= take;
      s2_valid_q <= s1_valid_q;
      dropped_q  <= dropped_q | (en & busy);
    end
  end

  always_ff @(posedge clk) begin
    s1_label_q <= label;
    s1_x_q     <= x;
    s1_y_q     <= y;
    s2_label_q <= s1_label_q;
    s2_entry_q <= merged;
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign busy      = (state_q != StAccum);
  assign dropped   = dropped_q;
  assign out_label = addr_q;
  assign out_min_x = dump_entry.min_x;
  assign out_max_x = dump_entry.max_x;
  assign out_min_y = dump_entry.min_y;
  assign out_max_y = dump_entry.max_y;
  assign out_area  = dump_entry.area;

endmodule

// File: tb/tb_bbox_collector.sv
// Randomised bench for bbox_collector: a per-label bounding-box model builds the expected
// record list for each frame and a negedge process compares every presented record against it.
module tb_bbox_collector;

  logic        clk = 1'b0;
  logic        reset, en, out_ready;
  logic [7:0]  label;
  logic [10:0] x, y;
  logic        busy, out_valid, frame_done, dropped;
  logic [7:0]  out_label;
  logic [10:0] out_min_x, out_max_x, out_min_y, out_max_y;
  logic [21:0] out_area;

  always #5 clk = ~clk;

  bbox_collector dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .label      (label),
    .x          (x),
    .y          (y),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_label  (out_label),
    .out_min_x  (out_min_x),
    .out_max_x  (out_max_x),
    .out_min_y  (out_min_y),
    .out_max_y  (out_max_y),
    .out_area   (out_area),
    .frame_done (frame_done),
    .dropped    (dropped)
  );

  typedef struct {
    int lbl;
    int minx;
    int maxx;
    int miny;
    int maxy;
    int area;
  } rec_t;

  int   checks = 0;
  int   errors = 0;
  rec_t exp_q[$];
  bit   done_pending = 0;
  int   rec_count = 0;

  bit m_vld [256];
  int m_minx[256], m_maxx[256], m_miny[256], m_maxy[256], m_area[256];

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, expv);
    end
  endtask

  // Compare process: every presented record must be the next one the model predicts.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_record: got label %0d required no record", out_label);
      end else begin
        chk("rec_label", int'(out_label), exp_q[0].lbl);
        chk("rec_min_x", int'(out_min_x), exp_q[0].minx);
        chk("rec_max_x", int'(out_max_x), exp_q[0].maxx);
        chk("rec_min_y", int'(out_min_y), exp_q[0].miny);
        chk("rec_max_y", int'(out_max_y), exp_q[0].maxy);
        chk("rec_area", int'(out_area), exp_q[0].area);
        if (out_ready) begin
          void'(exp_q.pop_front());
          rec_count++;
        end
      end
    end
    if (frame_done === 1'b1) begin
      chk("done_records_left", exp_q.size(), 0);
      chk("done_expected", int'(done_pending), 1);
      done_pending = 0;
    end
  end

  task automatic model_clear();
    for (int l = 0; l < 256; l++) m_vld[l] = 0;
  endtask

  task automatic pix(input int l, input int px, input int py);
    en    = 1'b1;
    label = l[7:0];
    x     = px[10:0];
    y     = py[10:0];
    if (!busy && l != 0) begin
      if (!m_vld[l]) begin
        m_vld[l] = 1;
        m_minx[l] = px; m_maxx[l] = px;
        m_miny[l] = py; m_maxy[l] = py;
        m_area[l] = 1;
      end else begin
        if (px < m_minx[l]) m_minx[l] = px;
        if (px > m_maxx[l]) m_maxx[l] = px;
        if (py < m_miny[l]) m_miny[l] = py;
        if (py > m_maxy[l]) m_maxy[l] = py;
        if (m_area[l] < (1 << 22) - 1) m_area[l]++;
      end
    end
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Frame-end pixel, then the model's expected record list in ascending label order.
  task automatic end_frame(input int l);
    pix(l, 639, 479);
    for (int i = 1; i < 256; i++) begin
      if (m_vld[i]) exp_q.push_back('{i, m_minx[i], m_maxx[i], m_miny[i], m_maxy[i], m_area[i]});
    end
    model_clear();
    done_pending = 1;
  endtask

  task automatic finish_frame(input int ready_pct, output int cycles);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (n < 3000 && !seen) begin
      out_ready = ($urandom_range(99) < ready_pct);
      @(posedge clk); #1;
      n++;
      if (frame_done) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL frame_done_timeout: got none in %0d cycles required a pulse", n);
    end
    out_ready = 1'b0;
    idle(1);
    cycles = n;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (n < 600 && !out_valid) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_out_valid", int'(out_valid), 1);
  endtask

  task automatic do_reset();
    int n;
    reset = 1'b1;
    en = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    done_pending = 0;
    model_clear();
    chk("reset_busy", int'(busy), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    chk("reset_dropped", int'(dropped), 0);
    reset = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy && n < 1000);
    chk("clear_cycles", n, 256);
  endtask

  task automatic rand_frame(input int npix);
    int l, px, py;
    l = 1;
    px = 0;
    for (int i = 0; i < npix; i++) begin
      // Half the time reuse the previous label at a neighbouring x to stress forwarding.
      if ($urandom_range(1) == 0 && l != 0) begin
        px = (px < 638) ? px + 1 : 0;
      end else begin
        case ($urandom_range(5))
          0:       l = 0;
          1:       l = 255;
          default: l = $urandom_range(12, 1);
        endcase
        px = $urandom_range(638);
      end
      py = $urandom_range(479);
      pix(l, px, py);
      idle($urandom_range(2));
    end
    end_frame($urandom_range(1) ? 0 : $urandom_range(12, 1));
  endtask

  initial begin
    int cyc, r0;
    reset = 1'b1;
    en = 1'b0;
    out_ready = 1'b0;
    label = '0;
    x = '0;
    y = '0;
    idle(2);
    do_reset();

    // Background-only frame: no records, frame_done after 2 drain + 255 dump cycles.
    r0 = rec_count;
    for (int i = 0; i < 8; i++) pix(0, i * 7, i * 3);
    end_frame(0);
    finish_frame(100, cyc);
    chk("empty_frame_latency", cyc, 257);
    chk("empty_frame_records", rec_count - r0, 0);

    // Single label 5 box.
    r0 = rec_count;
    pix(5, 10, 20); idle(1);
    pix(5, 12, 18); idle(2);
    pix(5, 11, 25);
    chk("m5_min_x", m_minx[5], 10);
    chk("m5_max_x", m_maxx[5], 12);
    chk("m5_min_y", m_miny[5], 18);
    chk("m5_max_y", m_maxy[5], 25);
    chk("m5_area", m_area[5], 3);
    end_frame(0);
    finish_frame(100, cyc);
    chk("l5_records", rec_count - r0, 1);

    // Label 7 on four consecutive cycles.
    r0 = rec_count;
    for (int i = 0; i < 4; i++) pix(7, 100 + i, 50);
    chk("m7_min_x", m_minx[7], 100);
    chk("m7_max_x", m_maxx[7], 103);
    chk("m7_area", m_area[7], 4);
    end_frame(0);
    finish_frame(100, cyc);
    chk("l7_records", rec_count - r0, 1);

    // Labels 3 and 9 with downstream stalled for 10 cycles on the first record.
    r0 = rec_count;
    pix(9, 200, 100);
    pix(3, 5, 6);
    pix(9, 190, 110);
    end_frame(0);
    wait_valid();
    idle(10);
    chk("stall_label", int'(out_label), 3);
    chk("stall_valid", int'(out_valid), 1);
    finish_frame(100, cyc);
    chk("l3_l9_records", rec_count - r0, 2);

    // Pixel offered while dumping is dropped and never reaches the table.
    chk("dropped_before", int'(dropped), 0);
    pix(4, 30, 40);
    pix(4, 31, 41);
    end_frame(0);
    idle(4);
    pix(20, 50, 50);
    chk("dropped_after", int'(dropped), 1);
    finish_frame(80, cyc);
    r0 = rec_count;
    pix(2, 1, 1);
    end_frame(0);
    finish_frame(100, cyc);
    chk("after_drop_records", rec_count - r0, 1);

    for (int f = 0; f < 4; f++) begin
      rand_frame(30 + f * 10);
      finish_frame(70, cyc);
    end

    // Reset after the first of two records has been taken.
    pix(1, 10, 10);
    pix(2, 20, 20);
    end_frame(0);
    wait_valid();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_dump_reset_valid", int'(out_valid), 0);
    do_reset();
    r0 = rec_count;
    pix(6, 300, 200);
    pix(6, 301, 199);
    end_frame(0);
    finish_frame(100, cyc);
    chk("post_reset_records", rec_count - r0, 1);

    rand_frame(40);
    finish_frame(60, cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bbox_collector.md
BBOX_COLLECTOR -- requirements
Module: bbox_collector

Interface
REQ-001 Parameter: LBL_WIDTH, 8, width of connected-component label; table depth 2^LBL_WIDTH.
REQ-002 Parameter: LOC_SIZE, 11, width of x/y pixel coordinates.
REQ-003 Parameter: FRAME_WIDTH, 640, pixels per row.
REQ-004 Parameter: FRAME_HEIGHT, 480, rows per frame.
REQ-005 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-006 Port: reset  input  1  synchronous, active-high reset.
REQ-007 Port: en  input  1  pixel strobe; label/x/y valid when high.
REQ-008 Port: label  input  LBL_WIDTH  connected-component label of current pixel; 0 = background.
REQ-009 Port: x  input  LOC_SIZE  column of current pixel.
REQ-010 Port: y  input  LOC_SIZE  row of current pixel.
REQ-011 Port: busy  output  1  high in CLEAR, DRAIN, DUMP, DONE; upstream must hold en low while high.
REQ-012 Port: out_valid  output  1  result record available.
REQ-013 Port: out_ready  input  1  downstream accepts record when out_valid && out_ready.
REQ-014 Port: out_label, out_min_x, out_max_x, out_min_y, out_max_y  output  LBL_WIDTH / LOC_SIZE x4  record fields.
REQ-015 Port: out_area  output  2*LOC_SIZE  pixel count of label, saturating.
REQ-016 Port: frame_done  output  1  one-cycle pulse after last record of a frame.
REQ-017 Port: dropped  output  1  sticky: en seen while busy; cleared only by reset.

Function
REQ-018 Table entry per label: valid bit, min_x, max_x, min_y, max_y, area; label 0 never stored or reported.
REQ-019 States: CLEAR, ACCUM, DRAIN, DUMP, DONE.
REQ-020 CLEAR: walk addresses 0..2^LBL_WIDTH-1, one per cycle, zeroing valid; then ACCUM.
REQ-021 ACCUM, en && label!=0: read-modify-write; entry invalid -> min=max=(x,y), area=1, valid=1; else min/max widen, area+1 saturating at all-ones.
REQ-022 Update pipeline: read stage, write stage; write commits 2 cycles after en sample.
REQ-023 Back-to-back same-label pixels (any spacing 1 or 2 cycles) forwarded from write stage; no update lost.
REQ-024 en && label==0: no table change.
REQ-025 Frame end: en && x==FRAME_WIDTH-1 && y==FRAME_HEIGHT-1 in ACCUM -> DRAIN after that pixel is taken into the pipeline.
REQ-026 DRAIN: 2 cycles to retire pipeline, then DUMP at address 1.
REQ-027 DUMP: invalid entry skipped in 1 cycle; valid entry presented on out_*, out_valid=1.
REQ-028 out_* stable while out_valid && !out_ready; on handshake entry cleared (valid=0), address+1.
REQ-029 After address 2^LBL_WIDTH-1 processed: DONE for 1 cycle, frame_done=1, then ACCUM.
REQ-030 Frame with no valid labels: DUMP takes 2^LBL_WIDTH-1 cycles, zero records, frame_done still pulses.
REQ-031 en high in CLEAR/DRAIN/DUMP/DONE: pixel discarded, dropped set.
REQ-032 out_valid never asserted outside DUMP.
REQ-033 Coordinates not range-checked except frame-end comparison.

Reset
REQ-034 reset high at any edge, any state: state=CLEAR, address=0, pipeline flushed, out_valid=0, frame_done=0, dropped=0, busy=1.
REQ-035 Reset mid-DUMP: unread records lost; no further out_valid until next frame's DUMP.
REQ-036 Table RAM contents not reset directly; CLEAR sequence guarantees empty table (2^LBL_WIDTH cycles, 256 default).

Verification
REQ-037 Reset, wait busy low (256 cycles), stream full frame label 0 -> frame_done once, no out_valid.
REQ-038 Label 5 at (10,20),(12,18),(11,25) -> one record: label 5, x 10..12, y 18..25, area 3.
REQ-039 Label 7 on 4 consecutive cycles at x=100..103, y=50 -> min_x 100, max_x 103, area 4 (forwarding).
REQ-040 Labels 3 and 9 present, out_ready low 10 cycles in DUMP -> record 3 held stable, then 3 before 9, frame_done after 9.
REQ-041 en pulsed during DUMP -> dropped=1, table unchanged; next frame output excludes that pixel.
REQ-042 reset asserted during DUMP after first of 2 records -> out_valid low next cycle, CLEAR rerun, next frame reports only its own labels.
